mux_tree_cfg_n: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 24 ++
 rtl/ccff_shift_reg.sv | 50 +++++
 rtl/mux_tree_cfg_n.sv | 91 +++++++++
 tb/tb_mux_tree_cfg_n.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared constants and elaboration helpers for the configurable routing muxes and LUT/IO
// config blocks that sit on the global ccff chain.
package fabric_cfg_pkg;

    localparam int unsigned CCFF_LSB_FIRST = 1;
    localparam logic        CONST1_VAL     = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // The tie-off code sits just past the last routed input.
    function automatic int unsigned const1_code(input int unsigned num_in);
        return num_in;
    endfunction

endpackage

// File: rtl/ccff_shift_reg.sv
// One slice of the serial configuration chain: a WIDTH-bit shift stage that advances while
// en is high and presents its outgoing bit as a registered tail.
module ccff_shift_reg
    import fabric_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             head,
    input  logic             en,
    output logic             tail,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_q_next;

    generate
        if (WIDTH == 1) begin : g_single
            assign w_shifted = head;
            assign tail      = r_q[0];
        end else if (CCFF_LSB_FIRST != 0) begin : g_lsb_first
            assign w_shifted = {head, r_q[WIDTH-1:1]};
            assign tail      = r_q[0];
        end else begin : g_msb_first
            assign w_shifted = {r_q[WIDTH-2:0], head};
            assign tail      = r_q[WIDTH-1];
        end
    endgenerate

    always_comb begin
        w_q_next = r_q;
        if (en) begin
            w_q_next = w_shifted;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mux_tree_cfg_n.sv
// Self-configured routing mux: a ccff shift slice feeds an atomically committed select code
// that steers a binary 2:1 mux tree over NUM_IN inputs padded with constant-1 leaves.
module mux_tree_cfg_n
    import fabric_cfg_pkg::*;
#(
    parameter  int unsigned NUM_IN  = 9,
    parameter  int unsigned OUT_REG = 0,
    localparam int unsigned SEL_W   = clog2(NUM_IN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_commit,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic              ccff_tail,
    output logic [SEL_W-1:0]  cfg_sel,
    output logic              cfg_err
);

    localparam int unsigned      LEAVES      = 1 << SEL_W;
    localparam logic [SEL_W-1:0] CONST1_CODE = SEL_W'(const1_code(NUM_IN));

    logic [SEL_W-1:0] w_shift;
    logic [SEL_W-1:0] r_active;
    logic             w_mux;

    ccff_shift_reg #(
        .WIDTH (SEL_W)
    ) u_ccff (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .head       (ccff_head),
        .en         (ccff_en),
        .tail       (ccff_tail),
        .q          (w_shift)
    );

    // Commit samples the pre-edge shift value, so a same-cycle shift never leaks in.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_active <= CONST1_CODE;
        end else if (cfg_commit) begin
            r_active <= w_shift;
        end
    end

    assign cfg_sel = r_active;
    assign cfg_err = (r_active > CONST1_CODE);

    // Level 0 holds the leaves; level l halves the width using select bit l-1.
    generate
        for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
            logic [(LEAVES >> l)-1:0] w_node;
            if (l == 0) begin : g_leaf
                for (genvar k = 0; k < LEAVES; k++) begin : g_k
                    if (k < NUM_IN) begin : g_in
                        assign w_node[k] = in[k];
                    end else begin : g_pad
                        assign w_node[k] = CONST1_VAL;
                    end
                end
            end else begin : g_mux
                for (genvar j = 0; j < (LEAVES >> l); j++) begin : g_j
                    assign w_node[j] = r_active[l-1] ? g_lvl[l-1].w_node[2*j+1]
                                                     : g_lvl[l-1].w_node[2*j];
                end
            end
        end
    endgenerate

    assign w_mux = g_lvl[SEL_W].w_node[0];

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic r_out;
            always_ff @(posedge prog_clk or negedge prog_rst_n) begin
                if (!prog_rst_n) begin
                    r_out <= CONST1_VAL;
                end else begin
                    r_out <= w_mux;
                end
            end
            assign out = r_out;
        end else begin : g_ocomb
            assign out = w_mux;
        end
    endgenerate

endmodule

// File: tb/tb_mux_tree_cfg_n.sv
// Bench for mux_tree_cfg_n: three instances (combinational, registered, and a chained
// downstream stage) checked against an arithmetic model of the chain and select rules.
module tb_mux_tree_cfg_n;

    localparam int N = 9;

    logic       prog_clk   = 1'b0;
    logic       prog_rst_n = 1'b1;
    logic       head   [3];
    logic       en     [3];
    logic       commit [3];
    logic [8:0] din    [3];
    logic       out_w  [3];
    logic       tail_w [3];
    logic [3:0] sel_w  [3];
    logic       err_w  [3];

    int   m_shift [3];
    int   m_act   [3];
    logic m_out1;
    int   total = 0;
    int   bad   = 0;

    always #5 prog_clk = ~prog_clk;

    mux_tree_cfg_n #(.NUM_IN(9), .OUT_REG(0)) dut0 (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .ccff_head(head[0]), .ccff_en(en[0]),
        .cfg_commit(commit[0]), .in(din[0]), .out(out_w[0]), .ccff_tail(tail_w[0]),
        .cfg_sel(sel_w[0]), .cfg_err(err_w[0])
    );

    mux_tree_cfg_n #(.NUM_IN(9), .OUT_REG(1)) dut1 (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .ccff_head(head[1]), .ccff_en(en[1]),
        .cfg_commit(commit[1]), .in(din[1]), .out(out_w[1]), .ccff_tail(tail_w[1]),
        .cfg_sel(sel_w[1]), .cfg_err(err_w[1])
    );

    // Downstream of dut0 on the chain.
    mux_tree_cfg_n #(.NUM_IN(9), .OUT_REG(0)) dut2 (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .ccff_head(tail_w[0]), .ccff_en(en[2]),
        .cfg_commit(commit[2]), .in(din[2]), .out(out_w[2]), .ccff_tail(tail_w[2]),
        .cfg_sel(sel_w[2]), .cfg_err(err_w[2])
    );

    function automatic logic msel(input int code, input logic [8:0] v);
        if (code < N) return v[code];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d);
        logic exp_out;
        exp_out = (d == 1) ? m_out1 : msel(m_act[d], din[d]);
        check($sformatf("d%0d_out", d), 32'(out_w[d]), 32'(exp_out));
        check($sformatf("d%0d_sel", d), 32'(sel_w[d]), 32'(m_act[d]));
        check($sformatf("d%0d_err", d), 32'(err_w[d]), 32'(m_act[d] > N));
        check($sformatf("d%0d_tail", d), 32'(tail_w[d]), 32'(m_shift[d] & 1));
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) check_dut(d);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_shift[d] = 0;
            m_act[d]   = N;
        end
        m_out1 = 1'b1;
    endtask

    // One clock edge: next model state is computed from pre-edge values, then compared.
    task automatic step();
        int   ns [3];
        int   na [3];
        int   h;
        logic no1;
        for (int d = 0; d < 3; d++) begin
            h     = (d == 2) ? (m_shift[0] & 1) : int'(head[d]);
            ns[d] = en[d] ? ((m_shift[d] >> 1) | (h << 3)) : m_shift[d];
            na[d] = commit[d] ? m_shift[d] : m_act[d];
        end
        no1 = msel(m_act[1], din[1]);
        @(posedge prog_clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            m_shift[d] = ns[d];
            m_act[d]   = na[d];
        end
        m_out1 = no1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        prog_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge prog_clk);
        #1;
        prog_rst_n = 1'b1;
    endtask

    task automatic shift_code(input int d, input int code);
        for (int b = 0; b < 4; b++) begin
            head[d] = 1'((code >> b) & 1);
            en[d]   = 1'b1;
            step();
        end
        en[d]   = 1'b0;
        head[d] = 1'b0;
    endtask

    task automatic commit_dut(input int d);
        commit[d] = 1'b1;
        step();
        commit[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        for (int d = 0; d < 3; d++) begin
            head[d] = 1'b0; en[d] = 1'b0; commit[d] = 1'b0; din[d] = '0;
        end
        model_reset();
        async_reset();

        // Idle after reset: inputs toggle, tie-off holds.
        for (int i = 0; i < 4; i++) begin
            din[0] = 9'($urandom);
            #1;
            check_all();
        end
        step();

        // Code 5 on dut0; active stays at the tie-off during the shift.
        shift_code(0, 5);
        check("d0_out_during_shift", 32'(out_w[0]), 32'd1);
        commit_dut(0);
        check("d0_sel5", 32'(sel_w[0]), 32'd5);
        for (int i = 0; i < 6; i++) begin
            din[0][4 + (i % 3)] = ~din[0][4 + (i % 3)];
            #1;
            check_all();
        end

        // Registered output: one edge of latency.
        shift_code(1, 2);
        commit_dut(1);
        din[1] = 9'h000;
        step();
        din[1][2] = 1'b1;
        #1;
        check("d1_out_before_edge", 32'(out_w[1]), 32'd0);
        step();
        check("d1_out_after_edge", 32'(out_w[1]), 32'd1);

        // Out-of-range, tie-off, and input 0.
        shift_code(0, 12);
        commit_dut(0);
        check("d0_err12", 32'(err_w[0]), 32'd1);
        shift_code(0, 9);
        commit_dut(0);
        check("d0_err9", 32'(err_w[0]), 32'd0);
        shift_code(0, 0);
        commit_dut(0);
        for (int i = 0; i < 3; i++) begin
            din[0][0] = ~din[0][0];
            #1;
            check_all();
        end

        // Commit and shift on the same edge.
        shift_code(0, 3);
        head[0] = 1'b1; en[0] = 1'b1; commit[0] = 1'b1;
        step();
        head[0] = 1'b0; en[0] = 1'b0; commit[0] = 1'b0;
        check("d0_sel_same_edge", 32'(sel_w[0]), 32'd3);
        check("d0_shift_same_edge", 32'(dut0.w_shift), 32'h9);
        check("d0_tail_same_edge", 32'(tail_w[0]), 32'd1);

        // Two-stage chain: 8 bits in, downstream holds the first four.
        pat = 8'hA6;
        en[0] = 1'b1; en[2] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            head[0] = pat[b];
            step();
        end
        en[0] = 1'b0; en[2] = 1'b0; head[0] = 1'b0;
        check("chain_up", 32'(dut0.w_shift), 32'(pat[7:4]));
        check("chain_down", 32'(dut2.w_shift), 32'(pat[3:0]));

        // Reset in the middle of a shift.
        head[0] = 1'b1; en[0] = 1'b1;
        step();
        step();
        en[0] = 1'b0;
        async_reset();
        check("d0_shift_after_rst", 32'(dut0.w_shift), 32'd0);
        shift_code(0, 6);
        commit_dut(0);
        check("d0_sel_after_rst", 32'(sel_w[0]), 32'd6);

        // Random traffic on all three instances.
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 3; d++) begin
                head[d]   = 1'($urandom);
                en[d]     = 1'($urandom);
                commit[d] = ($urandom_range(0, 3) == 0);
                din[d]    = 9'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
